key_expand_inv: RTL
===================

KEY_EXPAND_INV -- requirements
Module: key_expand_inv

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to begin inverse expansion; sampled on clk.
REQ-005 key_last  input  128  AES-128 round-10 key; word w0 = [127:96], w3 = [31:0].
REQ-006 busy  output  1  high while round keys are being produced.
REQ-007 rk_valid  output  1  rk/rk_round hold a valid round key this cycle.
REQ-008 rk  output  128  round key, same word ordering as key_last.
REQ-009 rk_round  output  4  round index of rk, 10 down to 0.
REQ-010 done  output  1  one-cycle pulse coincident with the round-0 key.
REQ-011 The block SHALL have no parameters.

Function
REQ-012 The block SHALL use two states, IDLE and RUN.
REQ-013 IDLE->RUN: start=1 in IDLE captures key_last into the key register; round counter loads 10.
REQ-014 Start issued in RUN SHALL be ignored and SHALL NOT disturb the sequence.
REQ-015 In RUN: rk = key register, rk_round = counter, rk_valid=1, busy=1.
REQ-016 Each RUN cycle with counter>0: key register <= previous-round key; counter decrements by 1.
REQ-017 Previous-round key from (w0,w1,w2,w3): v3=w3^w2, v2=w2^w1, v1=w1^w0, v0=w0^SubWord(RotWord(v3))^{Rcon(counter),24'h0}.
REQ-018 RotWord SHALL be a left byte rotation, {b0,b1,b2,b3} -> {b1,b2,b3,b0}.
REQ-019 SubWord SHALL apply the FIPS-197 forward S-box to each byte, combinational, inside this block.
REQ-020 Rcon(10..1) SHALL be 36,1b,80,40,20,10,08,04,02,01 (hex); the value for counter 0 is unused.
REQ-021 RUN->IDLE: the cycle with counter=0 outputs round 0 with done=1, then returns to IDLE.
REQ-022 Latency: start at edge T -> round 10 valid in cycle T+1, round k valid in cycle T+11-k, done in cycle T+11.
REQ-023 Exactly 11 rk_valid cycles per accepted start; no gaps.
REQ-024 start=1 in the done cycle SHALL be ignored; a new start is accepted only once the state is IDLE.
REQ-025 In IDLE: rk_valid=0, busy=0, done=0; rk and rk_round hold their last values.
REQ-026 key_last SHALL be sampled only at acceptance; later changes SHALL NOT affect the sequence.

Reset
REQ-027 rst=1 SHALL immediately force IDLE, counter=0, rk=0, rk_round=0, rk_valid=0, busy=0, done=0.
REQ-028 Reset asserted mid-RUN SHALL abort the sequence with no done pulse.
REQ-029 After rst deasserts, the first start SHALL be accepted normally.

Verification
REQ-030 FIPS-197 vector: key_last=d014f9a8c9ee2589e13f0cc8b6630ca6, start -> round 9 = ac7766f319fadc2128d12941575c006e; round 0 = 2b7e151628aed2a6abf7158809cf4f3c; done with round 0.
REQ-031 Timing: start pulse at edge T -> rk_valid high in cycles T+1..T+11, rk_round 10..0, busy low in cycle T+12.
REQ-032 start held high continuously -> sequences back to back, each 11 valid cycles, separated by one IDLE cycle.
REQ-033 Change key_last and pulse start while in RUN -> sequence unchanged, still ends at 2b7e1516... with done.
REQ-034 Assert rst at round 5 -> all outputs 0 at once, no done; the next start produces a full correct sequence.
REQ-035 Cross-check against a forward-expansion model on 100 random keys -> all 11 round keys match in reverse order.

Source files
------------

// File: rtl/key_expand_inv.sv
// Purpose : AES-128 inverse key expansion, walking from the round-10 key back to round 0.
// Latency : start accepted at edge T -> round 10 in cycle T+1, round 0 (with done) in cycle T+11.
// Backpressure: none; start is ignored while a sequence is running, including its done cycle.
module key_expand_inv (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_last,
    output logic         busy,
    output logic         rk_valid,
    output logic [127:0] rk,
    output logic [3:0]   rk_round,
    output logic         done
);

    typedef enum logic {IDLE, RUN} state_t;

    // Forward AES S-box, index 0 first.
    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        sub_word = {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    // Rcon of the round whose key is currently held; round 0 never needs one.
    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    state_t       state, state_nxt;
    logic [127:0] key_q, key_nxt;
    logic [3:0]   cnt_q, cnt_nxt;
    logic [127:0] prev_key;

    // Undo one forward-expansion step: recover round cnt-1 from round cnt.
    always_comb begin
        logic [31:0] w0, w1, w2, w3, v0, v1, v2, v3;
        w0 = key_q[127:96];
        w1 = key_q[95:64];
        w2 = key_q[63:32];
        w3 = key_q[31:0];
        v3 = w3 ^ w2;
        v2 = w2 ^ w1;
        v1 = w1 ^ w0;
        v0 = w0 ^ sub_word({v3[23:0], v3[31:24]}) ^ {rcon(cnt_q), 24'h0};
        prev_key = {v0, v1, v2, v3};
    end

    // State, key and round counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            key_q <= '0;
            cnt_q <= '0;
        end else begin
            state <= state_nxt;
            key_q <= key_nxt;
            cnt_q <= cnt_nxt;
        end
    end

    // Next-state logic and outputs; key and counter hold in IDLE so rk/rk_round keep their last values.
    always_comb begin
        state_nxt = state;
        key_nxt   = key_q;
        cnt_nxt   = cnt_q;
        rk        = key_q;
        rk_round  = cnt_q;
        busy      = 1'b0;
        rk_valid  = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    key_nxt   = key_last;
                    cnt_nxt   = 4'd10;
                end
            end
            RUN: begin
                busy     = 1'b1;
                rk_valid = 1'b1;
                if (cnt_q == 4'd0) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    key_nxt = prev_key;
                    cnt_nxt = cnt_q - 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
